fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch front end of the pipelined CPU. It owns the program counter, drives the instruction-memory address and captures the returned word into the IF/ID register. It then hands {instruction, PC, valid} to the decode stage, where the op/inst/imm/register fields are sliced.
It also accepts stall requests from hazard logic and taken-jump redirects from the memory stage (wpc & jmp), inserting bubbles as required.

Parameters:
PC_W, 32, program-counter / instruction-address width
INSTR_W, 32, instruction word width
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, sequential PC increment (byte-addressed words)
NOP_WORD, 0, word placed in IF/ID on a bubble (op=00, all enables 0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
stall_i  in  1  hold PC and IF/ID (load-use hazard)
jmp_i  in  1  taken jump from memory stage (wpc & jmp)
jmp_target_i  in  PC_W  jump destination address
imem_addr_o  out  PC_W  instruction-memory address (= current PC, combinational from PC reg)
imem_data_i  in  INSTR_W  instruction word, combinational read of imem_addr_o
if_instr_o  out  INSTR_W  IF/ID instruction register
if_pc_o  out  PC_W  PC of instruction in IF/ID
if_valid_o  out  1  IF/ID holds a real instruction
flush_o  out  1  one-cycle pulse: redirect taken, downstream must squash ID/EX
fetch_count_o  out  32  number of instructions delivered valid to decode

Behaviour:
- States: BOOT, RUN. 2-bit state register; the spare encoding goes to BOOT.
- Reset (rst=0 at clk edge), any state, mid-operation included:
  - PC=RESET_PC, if_instr_o=NOP_WORD, if_pc_o=0, if_valid_o=0, flush_o=0, fetch_count_o=0, state=BOOT.
- BOOT (first cycle with rst=1):
  - IF/ID loads imem_data_i at RESET_PC, if_pc_o=RESET_PC, if_valid_o=1.
  - PC=RESET_PC+PC_STEP; state becomes RUN.
  - stall_i and jmp_i are ignored in BOOT.
- RUN, per edge, priority jmp_i > stall_i > normal:
  - jmp_i=1: PC=jmp_target_i; IF/ID=NOP_WORD with if_valid_o=0 (wrong-path word discarded); flush_o=1 for the next cycle only. Stall in the same cycle is overridden.
  - stall_i=1, jmp_i=0: PC, if_instr_o, if_pc_o, if_valid_o and fetch_count_o all hold; flush_o=0.
  - Normal: IF/ID={imem_data_i, PC, valid=1}; PC=PC+PC_STEP; flush_o=0.
- Fetch latency: 1 cycle from address presentation to if_instr_o.
- Jump penalty: 1 bubble from fetch_stage; squashing the older ID/EX contents is downstream's job, triggered by flush_o.
- PC arithmetic is modulo 2^PC_W: 0xFFFFFFFC + 4 wraps to 0 with no flag. jmp_target_i is used unaligned, with no checking.
- fetch_count_o increments on every edge that loads if_valid_o=1 (BOOT and normal RUN loads). It wraps at 2^32.
- Back-to-back jmp_i cycles: each redirect wins; if_valid_o stays 0 and flush_o stays 1 while jmp_i is held.
- imem_addr_o always equals the PC register; there are no combinational paths from stall_i or jmp_i to imem_addr_o.

Test Plan:
- Reset/boot: rst=0 for 3 cycles, then 1; imem returns word = addr^0xA5000000.
  - Required: during reset valid=0, instr=0, count=0.
  - Edge 1: pc=0, instr=0xA5000000, valid=1.
  - Edge 2: pc=4, instr=0xA5000004; count=2.
- Stall: stall_i=1 for 2 cycles while IF/ID holds pc=8.
  - Required: if_pc_o stays 8, imem_addr_o stays 0xC, count unchanged.
  - After release: the next edge loads pc=0xC.
- Jump: at pc=0x10, assert jmp_i=1 with target 0x40 for one cycle.
  - Required next edge: valid=0, instr=NOP_WORD, flush_o=1, imem_addr_o=0x40.
  - Following edge: pc=0x40, valid=1, flush_o=0.
- Jump+stall simultaneous: jmp_i=1, stall_i=1, target 0x80.
  - Required: redirect taken (imem_addr_o=0x80, valid=0, flush_o=1); the stall is ignored.
- Wrap: jump to 0xFFFFFFFC, then 2 normal cycles.
  - Required: if_pc_o=0xFFFFFFFC, then 0x00000000; no X on any output.
- Mid-run reset: rst=0 during a stall at pc=0x24.
  - Required next edge: PC=0, valid=0, flush_o=0, count=0, state=BOOT.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives instruction memory and
// fills the IF/ID register, with load-use stalls and memory-stage redirects.
module fetch_stage #(
    parameter int unsigned        PC_W     = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               jmp_i,
    input  logic [PC_W-1:0]    jmp_target_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [PC_W-1:0]    if_pc_o,
    output logic               if_valid_o,
    output logic               flush_o,
    output logic [31:0]        fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01
    } state_t;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    state_t              state_r;
    logic [PC_W-1:0]     pc_r;
    logic [INSTR_W-1:0]  instr_r;
    logic [PC_W-1:0]     if_pc_r;
    logic                valid_r;
    logic                flush_r;
    logic [31:0]         count_r;

    // Fetch FSM: PC, IF/ID register, flush pulse and delivered-instruction count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= BOOT;
            pc_r    <= RESET_PC;
            instr_r <= NOP_WORD;
            if_pc_r <= '0;
            valid_r <= 1'b0;
            flush_r <= 1'b0;
            count_r <= 32'd0;
        end else begin
            case (state_r)
                BOOT: begin
                    // Stall and jump are ignored here so the reset vector is always fetched.
                    instr_r <= imem_data_i;
                    if_pc_r <= pc_r;
                    valid_r <= 1'b1;
                    flush_r <= 1'b0;
                    pc_r    <= pc_r + STEP;
                    count_r <= count_r + 32'd1;
                    state_r <= RUN;
                end
                RUN: begin
                    if (jmp_i) begin
                        // The word at the current PC is wrong-path; emit a bubble instead.
                        pc_r    <= jmp_target_i;
                        instr_r <= NOP_WORD;
                        valid_r <= 1'b0;
                        flush_r <= 1'b1;
                    end else if (stall_i) begin
                        flush_r <= 1'b0;
                    end else begin
                        instr_r <= imem_data_i;
                        if_pc_r <= pc_r;
                        valid_r <= 1'b1;
                        flush_r <= 1'b0;
                        pc_r    <= pc_r + STEP;
                        count_r <= count_r + 32'd1;
                    end
                    state_r <= RUN;
                end
                default: begin
                    flush_r <= 1'b0;
                    state_r <= BOOT;
                end
            endcase
        end
    end

    assign imem_addr_o   = pc_r;
    assign if_instr_o    = instr_r;
    assign if_pc_o       = if_pc_r;
    assign if_valid_o    = valid_r;
    assign flush_o       = flush_r;
    assign fetch_count_o = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; instruction memory returns addr ^ 0xA5000000.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jmp_i;
    logic [31:0] jmp_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_valid_o;
    logic        flush_o;
    logic [31:0] fetch_count_o;

    int checks;
    int failures;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .jmp_i         (jmp_i),
        .jmp_target_i  (jmp_target_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_valid_o    (if_valid_o),
        .flush_o       (flush_o),
        .fetch_count_o (fetch_count_o)
    );

    assign imem_data_i = imem_addr_o ^ 32'hA500_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then return at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_i = 1'b0; jmp_i = 1'b0; jmp_target_i = 32'h0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid_o); end
        checks++; if (if_instr_o !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", if_instr_o); end
        checks++; if (fetch_count_o !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fetch_count_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush_o); end
        rst = 1'b1;
        tick();
        checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL boot_pc got=%h exp=0", if_pc_o); end
        checks++; if (if_instr_o !== 32'hA500_0000) begin failures++; $display("FAIL boot_instr got=%h exp=a5000000", if_instr_o); end
        checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL boot_valid got=%b exp=1", if_valid_o); end
        checks++; if (imem_addr_o !== 32'h4) begin failures++; $display("FAIL boot_addr got=%h exp=4", imem_addr_o); end
        tick();
        checks++; if (if_pc_o !== 32'h4) begin failures++; $display("FAIL e2_pc got=%h exp=4", if_pc_o); end
        checks++; if (if_instr_o !== 32'hA500_0004) begin failures++; $display("FAIL e2_instr got=%h exp=a5000004", if_instr_o); end
        checks++; if (fetch_count_o !== 32'd2) begin failures++; $display("FAIL e2_count got=%0d exp=2", fetch_count_o); end
    endtask

    task automatic test_stall();
        tick();
        checks++; if (if_pc_o !== 32'h8) begin failures++; $display("FAIL pre_stall_pc got=%h exp=8", if_pc_o); end
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (if_pc_o !== 32'h8) begin failures++; $display("FAIL stall_pc got=%h exp=8", if_pc_o); end
            checks++; if (imem_addr_o !== 32'hC) begin failures++; $display("FAIL stall_addr got=%h exp=c", imem_addr_o); end
            checks++; if (fetch_count_o !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", fetch_count_o); end
            checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", if_valid_o); end
        end
        stall_i = 1'b0;
        tick();
        checks++; if (if_pc_o !== 32'hC) begin failures++; $display("FAIL unstall_pc got=%h exp=c", if_pc_o); end
        checks++; if (if_instr_o !== 32'hA500_000C) begin failures++; $display("FAIL unstall_instr got=%h exp=a500000c", if_instr_o); end
        checks++; if (fetch_count_o !== 32'd4) begin failures++; $display("FAIL unstall_count got=%0d exp=4", fetch_count_o); end
    endtask

    task automatic test_jump();
        checks++; if (imem_addr_o !== 32'h10) begin failures++; $display("FAIL pre_jmp_addr got=%h exp=10", imem_addr_o); end
        jmp_i = 1'b1; jmp_target_i = 32'h40;
        tick();
        jmp_i = 1'b0;
        checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL jmp_valid got=%b exp=0", if_valid_o); end
        checks++; if (if_instr_o !== 32'h0) begin failures++; $display("FAIL jmp_instr got=%h exp=0", if_instr_o); end
        checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL jmp_flush got=%b exp=1", flush_o); end
        checks++; if (imem_addr_o !== 32'h40) begin failures++; $display("FAIL jmp_addr got=%h exp=40", imem_addr_o); end
        checks++; if (fetch_count_o !== 32'd4) begin failures++; $display("FAIL jmp_count got=%0d exp=4", fetch_count_o); end
        tick();
        checks++; if (if_pc_o !== 32'h40) begin failures++; $display("FAIL post_jmp_pc got=%h exp=40", if_pc_o); end
        checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL post_jmp_valid got=%b exp=1", if_valid_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL post_jmp_flush got=%b exp=0", flush_o); end
        checks++; if (if_instr_o !== 32'hA500_0040) begin failures++; $display("FAIL post_jmp_instr got=%h exp=a5000040", if_instr_o); end
        checks++; if (fetch_count_o !== 32'd5) begin failures++; $display("FAIL post_jmp_count got=%0d exp=5", fetch_count_o); end
    endtask

    task automatic test_jump_stall();
        jmp_i = 1'b1; stall_i = 1'b1; jmp_target_i = 32'h80;
        tick();
        checks++; if (imem_addr_o !== 32'h80) begin failures++; $display("FAIL js_addr got=%h exp=80", imem_addr_o); end
        checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL js_valid got=%b exp=0", if_valid_o); end
        checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL js_flush got=%b exp=1", flush_o); end
        stall_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        jmp_i = 1'b1; jmp_target_i = 32'h90;
        tick();
        jmp_i = 1'b0;
        checks++; if (imem_addr_o !== 32'h90) begin failures++; $display("FAIL b2b_addr got=%h exp=90", imem_addr_o); end
        checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL b2b_flush got=%b exp=1", flush_o); end
        checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_valid got=%b exp=0", if_valid_o); end
        tick();
        checks++; if (if_pc_o !== 32'h90) begin failures++; $display("FAIL b2b_pc got=%h exp=90", if_pc_o); end
        checks++; if (fetch_count_o !== 32'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", fetch_count_o); end
    endtask

    task automatic test_wrap();
        jmp_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
        tick();
        jmp_i = 1'b0;
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_jaddr got=%h exp=fffffffc", imem_addr_o); end
        tick();
        checks++; if (if_pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", if_pc_o); end
        checks++; if (if_instr_o !== 32'h5AFF_FFFC) begin failures++; $display("FAIL wrap_instr1 got=%h exp=5afffffc", if_instr_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_addr_o); end
        tick();
        checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL wrap_pc2 got=%h exp=0", if_pc_o); end
        checks++; if (fetch_count_o !== 32'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", fetch_count_o); end
        checks++;
        if ((^{imem_addr_o, if_instr_o, if_pc_o, if_valid_o, flush_o, fetch_count_o}) === 1'bx) begin
            failures++; $display("FAIL wrap_no_x got=x exp=known");
        end
    endtask

    task automatic test_midrun_reset();
        jmp_i = 1'b1; jmp_target_i = 32'h24;
        tick();
        jmp_i = 1'b0;
        tick();
        stall_i = 1'b1;
        tick();
        checks++; if (if_pc_o !== 32'h24) begin failures++; $display("FAIL mr_hold_pc got=%h exp=24", if_pc_o); end
        checks++; if (fetch_count_o !== 32'd9) begin failures++; $display("FAIL mr_hold_count got=%0d exp=9", fetch_count_o); end
        rst = 1'b0;
        tick();
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL mr_addr got=%h exp=0", imem_addr_o); end
        checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", if_valid_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL mr_flush got=%b exp=0", flush_o); end
        checks++; if (fetch_count_o !== 32'd0) begin failures++; $display("FAIL mr_count got=%0d exp=0", fetch_count_o); end
        checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL mr_pc got=%h exp=0", if_pc_o); end
        // Boot must ignore both stall and jump requests.
        rst = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h200;
        tick();
        jmp_i = 1'b0; stall_i = 1'b0;
        checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL reboot_valid got=%b exp=1", if_valid_o); end
        checks++; if (imem_addr_o !== 32'h4) begin failures++; $display("FAIL reboot_addr got=%h exp=4", imem_addr_o); end
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL reboot_flush got=%b exp=0", flush_o); end
        checks++; if (fetch_count_o !== 32'd1) begin failures++; $display("FAIL reboot_count got=%0d exp=1", fetch_count_o); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0; stall_i = 1'b0; jmp_i = 1'b0; jmp_target_i = 32'h0;
        test_reset();
        test_stall();
        test_jump();
        test_jump_stall();
        test_back_to_back();
        test_wrap();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
